// File: rtl/max_result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : max_result_serializer_if
// Purpose  : Valid/ready word stream carrying the max-score result packet.
//            The master drives the words and the slave returns out_ready.
// Revision : 1.0 - initial release
// ============================================================================
interface max_result_serializer_if #(
   parameter int OUT_WIDTH = 8
);
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/max_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : max_result_serializer
// Purpose  : Snapshots the final max_score/max_row/max_col when an alignment
//            completes and streams them out as a packet of OUT_WIDTH-bit words
//            (score words, row words, col words, each LS word first).
//            Optional macro MAX_REPORT_CHECKSUM_EN appends an XOR checksum word.
// Revision : 1.0 - initial release
// ============================================================================
module max_result_serializer #(
   parameter int SCORE_WIDTH    = 8,
   parameter int ROW_BITS_WIDTH = 5,
   parameter int COL_BITS_WIDTH = 5,
   parameter int OUT_WIDTH      = 8
) (
   input  wire logic                      clk,
   input  wire logic                      rst_n,
   input  wire logic                      start,
   input  wire logic                      done_align,
   input  wire logic [SCORE_WIDTH-1:0]    max_score,
   input  wire logic [ROW_BITS_WIDTH-1:0] max_row,
   input  wire logic [COL_BITS_WIDTH-1:0] max_col,
   max_result_serializer_if.master        bus,
   output logic                           busy,
   output logic                           overrun
);

   // Words occupied by each zero-extended field
   localparam int c_score_words = (SCORE_WIDTH    + OUT_WIDTH - 1) / OUT_WIDTH;
   localparam int c_row_words   = (ROW_BITS_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
   localparam int c_col_words   = (COL_BITS_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
   localparam int c_field_words = c_score_words + c_row_words + c_col_words;
`ifdef MAX_REPORT_CHECKSUM_EN
   localparam int c_num_words   = c_field_words + 1;
`else
   localparam int c_num_words   = c_field_words;
`endif
   localparam int c_idx_w       = (c_num_words > 1) ? $clog2(c_num_words) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_words - 1);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_send = 1'b1;

   logic [0:0]                r_state;
   logic [c_idx_w-1:0]        r_index;
   logic                      r_overrun;
   logic [SCORE_WIDTH-1:0]    r_score;
   logic [ROW_BITS_WIDTH-1:0] r_row;
   logic [COL_BITS_WIDTH-1:0] r_col;

   logic [c_field_words*OUT_WIDTH-1:0] w_fields;
   logic [c_num_words*OUT_WIDTH-1:0]   w_packet;
   logic [OUT_WIDTH-1:0]               w_word;
   logic                               w_valid;
   logic                               w_last;
   logic                               w_accept;

   // Lay the snapshot out as a flat word array, unused upper bits left at zero
   always_comb begin
      w_fields = '0;
      w_fields[SCORE_WIDTH-1:0] = r_score;
      w_fields[c_score_words*OUT_WIDTH +: ROW_BITS_WIDTH] = r_row;
      w_fields[(c_score_words+c_row_words)*OUT_WIDTH +: COL_BITS_WIDTH] = r_col;
   end

`ifdef MAX_REPORT_CHECKSUM_EN
   logic [OUT_WIDTH-1:0] w_checksum;

   // Checksum word is the XOR of every field word that precedes it
   always_comb begin
      w_checksum = '0;
      for (int k = 0; k < c_field_words; k++) begin
         w_checksum = w_checksum ^ w_fields[k*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   assign w_packet = {w_checksum, w_fields};
`else
   assign w_packet = w_fields;
`endif

   // Select the word addressed by the current index
   always_comb begin
      w_word = '0;
      for (int k = 0; k < c_num_words; k++) begin
         if (r_index == c_idx_w'(k)) begin
            w_word = w_packet[k*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   assign w_valid  = (r_state == c_st_send);
   assign w_last   = w_valid && (r_index == c_last_idx);
   assign w_accept = w_valid && bus.out_ready;

   // Snapshot and index are frozen while a word waits, so data/last stay stable
   assign bus.out_valid = w_valid;
   assign bus.out_data  = w_valid ? w_word : '0;
   assign bus.out_last  = w_last;
   assign busy          = w_valid;
   assign overrun       = r_overrun;

   // Packet sequencing: start aborts, done_align launches or flags an overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_st_idle;
         r_index   <= '0;
         r_overrun <= 1'b0;
      end else if (start) begin
         r_state   <= c_st_idle;
         r_index   <= '0;
         r_overrun <= 1'b0;
      end else if (r_state == c_st_idle) begin
         if (done_align) begin
            r_state <= c_st_send;
            r_index <= '0;
         end
      end else begin
         if (done_align) begin
            r_overrun <= 1'b1;
         end
         if (w_accept) begin
            if (w_last) begin
               r_state <= c_st_idle;
               r_index <= '0;
            end else begin
               r_index <= r_index + c_idx_w'(1);
            end
         end
      end
   end

   // Capture the max registers only when idle and not being restarted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_score <= '0;
         r_row   <= '0;
         r_col   <= '0;
      end else if (!start && done_align && (r_state == c_st_idle)) begin
         r_score <= max_score;
         r_row   <= max_row;
         r_col   <= max_col;
      end
   end

endmodule
`default_nettype wire
